// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue slice.
//   - ALU ctrl code constants (ALU_ADD .. ALU_SRA)
//   - opcode (instruction[31:26]) and funct (instruction[5:0]) constants
//   - issue_t: one decoded entry headed for the EX stage
package alu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_NOR = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0]        ctrl;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [4:0]        dst;
        logic              reg_we;
        logic              illegal;
    } issue_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational translation of decoded instruction fields into an issue_t.
// Inputs : opcode, funct, shamt, imm, rt_idx, rd_idx, rs_val, rt_val
// Outputs: issue (ctrl, x, y, dst, reg_we, illegal)
// Unsupported opcode/funct yields an all-zero entry with illegal=1.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [4:0]        rt_idx,
    input  logic [4:0]        rd_idx,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output issue_t            issue
);

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_ext;
    logic [DATA_W-1:0] rs_shamt;

    assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};
    assign rs_shamt  = {{(DATA_W-5){1'b0}}, rs_val[4:0]};

    always_comb begin
        issue = '0;
        case (opcode)
            OP_RTYPE: begin
                issue.dst    = rd_idx;
                issue.reg_we = 1'b1;
                issue.x      = rs_val;
                issue.y      = rt_val;
                case (funct)
                    FN_ADD, FN_ADDU: issue.ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: issue.ctrl = ALU_SUB;
                    FN_AND:          issue.ctrl = ALU_AND;
                    FN_OR:           issue.ctrl = ALU_OR;
                    FN_XOR:          issue.ctrl = ALU_XOR;
                    FN_NOR:          issue.ctrl = ALU_NOR;
                    FN_SLT:          issue.ctrl = ALU_SLT;
                    FN_SLL:  begin issue.ctrl = ALU_SLL; issue.x = shamt_ext; end
                    FN_SRL:  begin issue.ctrl = ALU_SRL; issue.x = shamt_ext; end
                    FN_SRA:  begin issue.ctrl = ALU_SRA; issue.x = shamt_ext; end
                    FN_SLLV: begin issue.ctrl = ALU_SLL; issue.x = rs_shamt; end
                    FN_SRLV: begin issue.ctrl = ALU_SRL; issue.x = rs_shamt; end
                    FN_SRAV: begin issue.ctrl = ALU_SRA; issue.x = rs_shamt; end
                    default: begin
                        issue         = '0;
                        issue.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                issue.x      = rs_val;
                issue.dst    = rt_idx;
                issue.reg_we = 1'b1;
                case (opcode)
                    OP_SLTI: begin issue.ctrl = ALU_SLT; issue.y = imm_sext; end
                    OP_ANDI: begin issue.ctrl = ALU_AND; issue.y = imm_zext; end
                    OP_ORI:  begin issue.ctrl = ALU_OR;  issue.y = imm_zext; end
                    OP_XORI: begin issue.ctrl = ALU_XOR; issue.y = imm_zext; end
                    default: begin issue.ctrl = ALU_ADD; issue.y = imm_sext; end
                endcase
            end
            OP_LUI: begin
                // lui is a left shift of the immediate by 16
                issue.ctrl   = ALU_SLL;
                issue.x      = DATA_W'(16);
                issue.y      = imm_zext;
                issue.dst    = rt_idx;
                issue.reg_we = 1'b1;
            end
            OP_SW: begin
                issue.ctrl = ALU_ADD;
                issue.x    = rs_val;
                issue.y    = imm_sext;
            end
            OP_BEQ, OP_BNE: begin
                issue.ctrl = ALU_SUB;
                issue.x    = rs_val;
                issue.y    = rt_val;
            end
            default: begin
                issue.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID-to-EX issue stage for the ALU.
// Inputs : clk, rst_n, flush, in_valid + instruction fields, rs_val/rt_val, out_ready
// Outputs: in_ready, out_valid, ctrl, x, y, dst, reg_we, illegal
// Main register M drives the outputs; skid register S absorbs one extra entry so that
// in_ready comes straight from a flop (!S.valid) with no path from out_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [4:0]   shamt,
    input  logic [15:0]  imm,
    input  logic [4:0]   rt_idx,
    input  logic [4:0]   rd_idx,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   ctrl,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [4:0]   dst,
    output logic         reg_we,
    output logic         illegal
);

    issue_t dec;
    issue_t m_q, m_d, s_q, s_d;
    logic   m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic   accept, drain;

    alu_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .shamt  (shamt),
        .imm    (imm),
        .rt_idx (rt_idx),
        .rd_idx (rd_idx),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .issue  (dec)
    );

    assign in_ready = !s_valid_q;
    assign accept   = in_valid && !s_valid_q;
    assign drain    = m_valid_q && out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            // S full means in_ready is low, so no accept can coincide here
            if (drain) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q || drain) begin
                m_d       = dec;
                m_valid_d = 1'b1;
            end else begin
                s_d       = dec;
                s_valid_d = 1'b1;
            end
        end else if (drain) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid = m_valid_q;
    assign ctrl      = m_q.ctrl;
    assign x         = m_q.x;
    assign y         = m_q.y;
    assign dst       = m_q.dst;
    assign reg_we    = m_q.reg_we;
    assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  dst;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] imm = '0;
    logic [4:0]  rt_idx = '0;
    logic [4:0]  rd_idx = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  ctrl;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  dst;
    logic        reg_we;
    logic        illegal;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    alu_issue #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct     (funct),
        .shamt     (shamt),
        .imm       (imm),
        .rt_idx    (rt_idx),
        .rd_idx    (rd_idx),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl      (ctrl),
        .x         (x),
        .y         (y),
        .dst       (dst),
        .reg_we    (reg_we),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the operation by name, then derive operands from the instruction rules.
    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] sh, input logic [15:0] im,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [31:0] rsv, input logic [31:0] rtv);
        exp_t e;
        logic signed [31:0] se;
        logic [31:0] ze;
        string       opn;
        se = $signed(im);
        ze = 32'(im);
        e.ctrl = 0; e.x = 0; e.y = 0; e.dst = 0; e.we = 0; e.ill = 0;
        opn = "bad";
        if (op == 6'h00) begin
            e.x = rsv; e.y = rtv; e.dst = rd; e.we = 1;
            case (fn)
                6'h20, 6'h21: opn = "add";
                6'h22, 6'h23: opn = "sub";
                6'h24: opn = "and";
                6'h25: opn = "or";
                6'h26: opn = "xor";
                6'h27: opn = "nor";
                6'h2A: opn = "slt";
                6'h00: begin opn = "sll"; e.x = 32'(sh); end
                6'h02: begin opn = "srl"; e.x = 32'(sh); end
                6'h03: begin opn = "sra"; e.x = 32'(sh); end
                6'h04: begin opn = "sll"; e.x = rsv % 32; end
                6'h06: begin opn = "srl"; e.x = rsv % 32; end
                6'h07: begin opn = "sra"; e.x = rsv % 32; end
                default: opn = "bad";
            endcase
        end else begin
            e.x = rsv; e.dst = rt; e.we = 1;
            case (op)
                6'h08, 6'h09, 6'h23: begin opn = "add"; e.y = se; end
                6'h0A: begin opn = "slt"; e.y = se; end
                6'h0C: begin opn = "and"; e.y = ze; end
                6'h0D: begin opn = "or";  e.y = ze; end
                6'h0E: begin opn = "xor"; e.y = ze; end
                6'h0F: begin opn = "sll"; e.x = 16; e.y = ze; end
                6'h2B: begin opn = "add"; e.y = se; e.we = 0; end
                6'h04, 6'h05: begin opn = "sub"; e.y = rtv; e.we = 0; end
                default: opn = "bad";
            endcase
        end
        case (opn)
            "add": e.ctrl = 4'd0;
            "sub": e.ctrl = 4'd1;
            "and": e.ctrl = 4'd2;
            "or":  e.ctrl = 4'd3;
            "slt": e.ctrl = 4'd4;
            "xor": e.ctrl = 4'd5;
            "nor": e.ctrl = 4'd6;
            "sll": e.ctrl = 4'd7;
            "srl": e.ctrl = 4'd8;
            "sra": e.ctrl = 4'd9;
            default: begin
                e.ctrl = 0; e.x = 0; e.y = 0; e.dst = 0; e.we = 0; e.ill = 1;
            end
        endcase
        return e;
    endfunction

    // One cycle of stimulus. Occupancy of the scoreboard is the number of held entries,
    // so in_ready must be high exactly when fewer than two are held.
    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] im,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic ord, input logic fl);
        logic acc;
        logic [4:0] rt, rd;
        rt = 5'($urandom);
        rd = 5'($urandom);
        @(negedge clk);
        in_valid = v; opcode = op; funct = fn; shamt = sh; imm = im;
        rt_idx = rt; rd_idx = rd; rs_val = rsv; rt_val = rtv;
        out_ready = ord; flush = fl;
        #1;
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        acc = v && (sb.size() < 2);
        #2;
        if (acc && !fl) sb.push_back(ref_model(op, fn, sh, im, rt, rd, rsv, rtv));
    endtask

    task automatic idle(input logic ord);
        drive(1'b0, 6'($urandom), 6'($urandom), 5'($urandom), 16'($urandom),
              $urandom, $urandom, ord, 1'b0);
    endtask

    task automatic dir(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] rsv, input logic [31:0] rtv);
        drive(1'b1, op, fn, sh, im, rsv, rtv, 1'b1, 1'b0);
        idle(1'b1);
    endtask

    task automatic rand_beat(input logic ord, input logic fl);
        logic [5:0] ops [13];
        logic [5:0] fns [16];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                6'h23, 6'h2B, 6'h04};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00,
                6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h05};
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
        fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
        drive($urandom_range(0, 9) < 7, op, fn, 5'($urandom), 16'($urandom),
              $urandom, $urandom, ord, fl);
    endtask

    // Monitor: pops and compares whenever EX takes an entry; also checks hold stability.
    initial begin
        logic        held;
        logic [3:0]  p_ctrl;
        logic [31:0] p_x, p_y;
        logic [4:0]  p_dst;
        logic        p_we, p_ill;
        exp_t        e;
        held = 0;
        p_ctrl = 0; p_x = 0; p_y = 0; p_dst = 0; p_we = 0; p_ill = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                held = 0;
                continue;
            end
            chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
            if (held && out_valid) begin
                chk("hold_ctrl", 32'(ctrl), 32'(p_ctrl));
                chk("hold_x", x, p_x);
                chk("hold_y", y, p_y);
                chk("hold_flags", {dst, reg_we, illegal}, {p_dst, p_we, p_ill});
            end
            if (flush) begin
                sb.delete();
            end else if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctrl", 32'(ctrl), 32'(e.ctrl));
                chk("x", x, e.x);
                chk("y", y, e.y);
                chk("reg_we", 32'(reg_we), 32'(e.we));
                chk("illegal", 32'(illegal), 32'(e.ill));
                if (e.we) chk("dst", 32'(dst), 32'(e.dst));
            end
            held = out_valid && !out_ready;
            p_ctrl = ctrl; p_x = x; p_y = y; p_dst = dst; p_we = reg_we; p_ill = illegal;
        end
    end

    initial begin
        // Reset with random inputs toggling
        #1 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); opcode = 6'($urandom); funct = 6'($urandom);
            imm = 16'($urandom); rs_val = $urandom; rt_val = $urandom;
            out_ready = 1'($urandom); flush = 1'($urandom);
        end
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_dst", 32'(dst), 0);
        chk("rst_flags", {reg_we, illegal}, 0);
        @(negedge clk);
        in_valid = 0; flush = 0; rst_n = 1'b1; mon_en = 1'b1;

        // Decode sweep; each entry is visible one cycle after acceptance
        dir(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd9);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_ctrl", 32'(ctrl), 0);
        chk("addi_y", y, 32'hFFFF_FFFF);
        dir(6'h0D, 6'h00, 5'd0, 16'h8000, 32'd1, 32'd2);
        chk("ori_y", y, 32'h0000_8000);
        dir(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD, 32'd2);
        chk("lui_ctrl", 32'(ctrl), 7);
        chk("lui_x", x, 16);
        chk("lui_y", y, 32'h0000_1234);
        dir(6'h00, 6'h03, 5'd4, 16'h0000, 32'h55, 32'h8000_0000);
        chk("sra_ctrl", 32'(ctrl), 9);
        chk("sra_x", x, 4);
        dir(6'h2B, 6'h00, 5'd0, 16'h0010, 32'h100, 32'd0);
        chk("sw_we", 32'(reg_we), 0);
        chk("sw_ctrl", 32'(ctrl), 0);
        dir(6'h04, 6'h00, 5'd0, 16'h0003, 32'd7, 32'd7);
        chk("beq_ctrl", 32'(ctrl), 1);
        chk("beq_xy", {x, y}, {32'd7, 32'd7});
        dir(6'h3F, 6'h20, 5'd3, 16'hABCD, 32'd11, 32'd12);
        chk("ill_valid", 32'(out_valid), 1);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_ctrl_we", {ctrl, reg_we}, 0);
        chk("ill_xy", {x, y}, 0);
        idle(1'b1);

        // Back-pressure: A held, B skidded, C waits at the source
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 32'hA, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 32'hB, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 32'hC, 32'd1, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_head", x, 32'hA);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 32'hC, 32'd1, 1'b1, 1'b0);
        drive(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 32'hC, 32'd1, 1'b1, 1'b0);
        chk("bp_second", x, 32'hB);
        idle(1'b1);
        chk("bp_third", x, 32'hC);
        idle(1'b1);

        // Flush with M and S full and a new input offered
        drive(1'b1, 6'h0D, 6'h00, 5'd0, 16'h1111, 32'd1, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 6'h0D, 6'h00, 5'd0, 16'h2222, 32'd2, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 6'h0D, 6'h00, 5'd0, 16'h3333, 32'd3, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        idle(1'b1);

        // Reset asserted while two entries are held
        drive(1'b1, 6'h0E, 6'h00, 5'd0, 16'h4444, 32'd4, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 6'h0E, 6'h00, 5'd0, 16'h5555, 32'd5, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 0;
        #5;
        rst_n = 1'b0; mon_en = 1'b0;
        sb.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; mon_en = 1'b1;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) rand_beat(1'b0, 1'b1);
            else rand_beat($urandom_range(0, 9) < 6, 1'b0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Producer end of the ALU control interface. Accepts one decoded instruction per cycle (opcode, funct, shamt, immediate, register operand values) over a valid/ready handshake. Translates it into the 4-bit ALU `ctrl` code and the `x`/`y` operands, and registers the result toward the EX stage. A 2-entry skid buffer absorbs EX back-pressure without a combinational `ready` path. It sits between the ID stage and the combinational ALU, in both the baseline and L2Cache builds.

## Interface
- `W`, 32: datapath width of `x`/`y`/`rs_val`/`rt_val`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous pipeline kill; discards all held entries.
- `in_valid`  in  1: instruction fields valid.
- `in_ready`  out  1: block can accept this cycle.
- `opcode`  in  6: instruction[31:26].
- `funct`  in  6: instruction[5:0].
- `shamt`  in  5: instruction[10:6].
- `imm`  in  16: instruction[15:0].
- `rt_idx`  in  5: instruction[20:16].
- `rd_idx`  in  5: instruction[15:11].
- `rs_val`  in  W: forwarded rs value.
- `rt_val`  in  W: forwarded rt value.
- `out_valid`  out  1: EX entry valid.
- `out_ready`  in  1: EX consumes the entry.
- `ctrl`  out  4: ALU operation code.
- `x`  out  W: ALU operand x; carries the shift amount for shifts.
- `y`  out  W: ALU operand y; carries the shifted value for shifts.
- `dst`  out  5: writeback register index.
- `reg_we`  out  1: writeback enable.
- `illegal`  out  1: unsupported opcode/funct.

## Operation
- ctrl codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, XOR 0101, NOR 0110, SLL 0111, SRL 1000, SRA 1001.
- R-type (opcode 0x00): `dst`=`rd_idx`, `reg_we`=1, `y`=`rt_val`.
  - funct 20/21→ADD, 22/23→SUB, 24→AND, 25→OR, 26→XOR, 27→NOR, 2A→SLT; `x`=`rs_val`.
  - funct 00/02/03→SLL/SRL/SRA with `x`={27'b0,`shamt`}.
  - funct 04/06/07→SLL/SRL/SRA with `x`={27'b0,`rs_val[4:0]`}.
- I-type: `x`=`rs_val`, `dst`=`rt_idx`, `reg_we`=1.
  - 08/09→ADD, sign-extended imm.
  - 0A→SLT, sign-extended imm.
  - 0C→AND, 0D→OR, 0E→XOR, each zero-extended imm.
  - 0F (lui)→SLL with `x`=16 and `y`=zero-extended imm.
  - 23 (lw)→ADD, sign-extended imm.
- No writeback: 2B (sw)→ADD with sign-extended imm, `reg_we`=0. 04/05 (beq/bne)→SUB with `y`=`rt_val`, `reg_we`=0.
- Any other opcode/funct: `ctrl`=0000, `x`=`y`=0, `reg_we`=0, `illegal`=1. The entry still flows through; it is not dropped.
- Sign extension: imm[15] replicated to W bits. Zero extension: upper W-16 bits are 0.
- Buffer: main register M (drives the outputs) plus skid register S.
  - `in_ready` = !S.valid, taken straight from the register.
  - Accept (`in_valid`&&`in_ready`):
    - M empty or M draining (`out_ready`): decoded entry → M.
    - Otherwise: decoded entry → S.
  - M drains while S is full: S → M, S clears.
- Order is strictly preserved; at most 2 entries are in flight.

## Timing
- Reset (`rst_n`=0, asynchronous): M and S invalid. `out_valid`=0, `ctrl`=0, `x`=0, `y`=0, `dst`=0, `reg_we`=0, `illegal`=0. `in_ready`=1.
- Latency: an entry accepted in cycle N shows on the outputs with `out_valid`=1 in N+1 when M was empty or draining.
- Throughput: 1 entry per cycle while `out_ready`=1.
- Outputs hold stable while `out_valid`&&!`out_ready`.
- `in_ready` falls the cycle after S fills. It rises the cycle after S drains.
- `flush`=1: M and S invalid next cycle; any input accepted that cycle is discarded. `flush` takes priority over accept and drain. `in_ready`=1 the next cycle.
- Reset asserted mid-transfer: all entries are lost immediately and no partial entry is emitted.

## Structure
- Package `alu_pkg` holds:
  - the ctrl code localparams (ALU_ADD … ALU_SRA);
  - opcode and funct constants;
  - a packed struct `issue_t` {ctrl, x, y, dst, reg_we, illegal}.
- Sub-module `alu_decode`: purely combinational field → `issue_t` translation. `alu_issue` owns only the M/S registers and the handshake logic.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0, `in_ready`=1. Release → first valid beat emerges 1 cycle after accept.
- Decode sweep: addi with imm 0xFFFF, `rs_val`=5 → `ctrl`=0000, `y`=0xFFFFFFFF. ori with imm 0x8000 → `y`=0x00008000. lui with imm 0x1234 → `ctrl`=0111, `x`=16, `y`=0x00001234. sra with shamt=4 → `ctrl`=1001, `x`=4.
- Back-pressure: stream A, B, C with `out_ready`=0 → A held on the outputs, B in S, `in_ready`=0, C held by the source. Raise `out_ready` → A, B, C delivered in order, one per cycle.
- Store/branch: sw → `reg_we`=0, `ctrl`=0000. beq with `rs_val`=`rt_val`=7 → `ctrl`=0001, `x`=7, `y`=7.
- Illegal: opcode 0x3F → `illegal`=1, `ctrl`=0, `x`=`y`=0, `reg_we`=0, `out_valid`=1.
- Flush: M and S full and `in_valid`=1 with `flush`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed entries never appear.
